// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and constants for the ALU control decoder and MDU sequencer
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_ARITH  = 2'b10,
        ALUOP_JUMP   = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BGE  = 4'b1010,
        OP_BGEU = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_JAL  = 4'b1101,
        OP_SLTU = 4'b1110
    } alu_op_e;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_controller_mdu_iter.sv
// rtl/alu_controller_mdu_iter.sv - iterative shift-add multiplier / restoring divider datapath (divider under ALU_CTRL_MDU_DIV_EN)
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            special_o,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [2:0]        f3_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              a_sgn, b_sgn, a_neg, b_neg, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag, spec_val;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
`ifdef ALU_CTRL_MDU_DIV_EN
    logic              spec_q;
    logic [XLEN:0]     shifted, diff;
`endif

    // Remainder follows the dividend; products and quotients follow the XOR of signs.
    always_comb begin
        a_sgn   = funct3_i[2] ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_sgn   = funct3_i[2] ? !funct3_i[0] : !funct3_i[1];
        a_neg   = a_sgn && rs1_i[XLEN-1];
        b_neg   = b_sgn && rs2_i[XLEN-1];
        a_mag   = a_neg ? (XLEN'(0) - rs1_i) : rs1_i;
        b_mag   = b_neg ? (XLEN'(0) - rs2_i) : rs2_i;
        res_neg = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

`ifdef ALU_CTRL_MDU_DIV_EN
    assign special_o = funct3_i[2] && ((rs2_i == '0) ||
                       (!funct3_i[0] && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1));
    assign spec_val  = (rs2_i == '0) ? (funct3_i[1] ? rs1_i : '1)
                                     : (funct3_i[1] ? '0 : rs1_i);
`else
    assign special_o = 1'b0;
    assign spec_val  = '0;
`endif

    always_comb begin
        acc_d = acc_q;
        sum   = '0;
`ifdef ALU_CTRL_MDU_DIV_EN
        shifted = '0;
        diff    = '0;
`endif
        for (int i = 0; i < UNROLL; i++) begin
`ifdef ALU_CTRL_MDU_DIV_EN
            if (f3_q[2]) begin
                shifted = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
                diff    = shifted - {1'b0, mcand_q};
                if (shifted >= {1'b0, mcand_q})
                    acc_d = {diff[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
                else
                    acc_d = {shifted[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
            end else
`endif
            begin
                sum   = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, mcand_q} : '0);
                acc_d = {sum, acc_d[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f3_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
`ifdef ALU_CTRL_MDU_DIV_EN
            spec_q  <= 1'b0;
`endif
        end else if (load_i) begin
            f3_q    <= funct3_i;
            neg_q   <= res_neg;
            mcand_q <= b_mag;
            cnt_q   <= CNT_W'(STEPS);
            acc_q   <= special_o ? {{XLEN{1'b0}}, spec_val} : {{XLEN{1'b0}}, a_mag};
`ifdef ALU_CTRL_MDU_DIV_EN
            spec_q  <= special_o;
`endif
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_o  = (cnt_q == CNT_W'(1));
    assign prod    = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
    assign mul_res = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef ALU_CTRL_MDU_DIV_EN
    always_comb begin
        if (spec_q)
            result_o = acc_q[XLEN-1:0];
        else if (f3_q[2] && f3_q[1])
            result_o = neg_q ? (XLEN'(0) - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        else if (f3_q[2])
            result_o = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        else
            result_o = mul_res;
    end
`else
    assign result_o = mul_res;
`endif

endmodule

// File: rtl/alu_controller_mdu.sv
// rtl/alu_controller_mdu.sv - RV32I ALU control decode plus RV32M sequencer; ALU_CTRL_MDU_DIV_EN enables divide
module alu_controller_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int OP_W   = 4,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            valid_i,
    input  logic            is_rtype_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [OP_W-1:0] Operation,
    output logic            mdu_sel_o,
    output logic            stall_o,
    output logic [XLEN-1:0] mdu_result_o,
    output logic            mdu_done_o,
    output logic            illegal_o
);

    mdu_state_e      state_q, state_d;
    alu_op_e         op;
    logic            m_op, accept, load, step, special, last;
    logic [XLEN-1:0] iter_result;

    assign m_op = is_rtype_i && (ALUOp == ALUOP_ARITH) && (Funct7 == FUNCT7_MEXT);

`ifdef ALU_CTRL_MDU_DIV_EN
    assign illegal_o = 1'b0;
`else
    assign illegal_o = m_op && Funct3[2];
`endif

    always_comb begin
        op = OP_ADD;
        case (aluop_e'(ALUOp))
            ALUOP_MEM:  op = OP_ADD;
            ALUOP_JUMP: op = OP_JAL;
            ALUOP_BRANCH: begin
                case (Funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_SLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_SLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ADD;
                endcase
            end
            default: begin
                if (!m_op) begin
                    case (Funct3)
                        3'b000:  op = (Funct7 == FUNCT7_ALT && is_rtype_i) ? OP_SUB : OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = (Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end
            end
        endcase
    end

    assign Operation = OP_W'(op);
    assign mdu_sel_o = m_op;
    assign accept    = valid_i && m_op && !flush_i && !illegal_o;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush_i)   state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The stalled instruction is still presented in DONE, so nothing is re-accepted there.
    always_comb begin
        load         = (state_q == ST_IDLE) && accept;
        step         = (state_q == ST_BUSY) && !flush_i;
        stall_o      = (load && reset_n) || (state_q == ST_BUSY);
        mdu_done_o   = (state_q == ST_DONE) && !flush_i;
        mdu_result_o = mdu_done_o ? iter_result : '0;
    end

    mdu_iter #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (load),
        .step_i    (step),
        .funct3_i  (Funct3),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .special_o (special),
        .last_o    (last),
        .result_o  (iter_result)
    );

endmodule
